// File: rtl/fpu_pkg.sv
// Shared FPU types: fdiv pipeline latency and in-flight result ownership tags.
package fpu_pkg;

  localparam int unsigned FDIV_LAT = 5;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } fdiv_tag_t;

endpackage

// File: rtl/fdiv_arb_fifo.sv
// Synchronous FIFO with count/full/empty and no write-to-read bypass.
module fdiv_arb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_rd;

  // Wrap-around increment that also works for non-power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_rd = rd_en && (count_q != '0);

  // Pointer and occupancy update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({wr_en, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);

  // The credit scheme upstream must never let a write land on a full FIFO.
  no_overflow_a: assert property (@(posedge clk) disable iff (!rstn) wr_en |-> !full);

endmodule

// File: rtl/fdiv_arb.sv
// Two-requester round-robin arbiter for the free-running fdiv pipeline, with
// credit-based back-pressure and per-requester result FIFOs.
module fdiv_arb
  import fpu_pkg::*;
#(
  parameter int unsigned LAT    = FDIV_LAT,
  parameter int unsigned FIFO_D = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x1,
  input  logic [31:0] req0_x2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x1,
  input  logic [31:0] req1_x2,
  output logic        fdiv_en,
  output logic [31:0] fdiv_x1,
  output logic [31:0] fdiv_x2,
  input  logic [31:0] fdiv_y,
  output logic        res0_valid,
  input  logic        res0_ready,
  output logic [31:0] res0_y,
  output logic        res1_valid,
  input  logic        res1_ready,
  output logic [31:0] res1_y
);

  localparam int unsigned CW = $clog2(FIFO_D + 1);

  logic [CW-1:0] free_q [2];
  logic [CW-1:0] free_d [2];
  logic [1:0]    elig, grant, pop, wr_en;
  req_id_t       prio_q, prio_d;
  req_id_t       owner_q;
  logic          fdiv_en_q;
  logic [31:0]   fdiv_x1_q, fdiv_x2_q;
  fdiv_tag_t     tag_q [LAT];
  fdiv_tag_t     tail;
  logic [CW-1:0] count0, count1;
  logic          full0, full1, empty0, empty1;

  assign elig[0] = req0_valid && (free_q[0] != '0);
  assign elig[1] = req1_valid && (free_q[1] != '0);

  // Round-robin pick: prio wins a tie, otherwise the lone eligible requester.
  always_comb begin
    grant = '0;
    if (elig[0] && elig[1]) grant[prio_q] = 1'b1;
    else                    grant = elig;
  end

  // Priority passes to whichever requester lost (or was absent) at a grant.
  always_comb begin
    prio_d = prio_q;
    if (grant[0])      prio_d = 1'b1;
    else if (grant[1]) prio_d = 1'b0;
  end

  // Ready is forced low while reset is asserted.
  assign req0_ready = grant[0] && rstn;
  assign req1_ready = grant[1] && rstn;

  assign pop[0] = res0_valid && res0_ready;
  assign pop[1] = res1_valid && res1_ready;

  // Credit bookkeeping: grant consumes, pop returns, both together cancel.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      free_d[i] = free_q[i];
      if (grant[i] && !pop[i])      free_d[i] = free_q[i] - 1'b1;
      else if (!grant[i] && pop[i]) free_d[i] = free_q[i] + 1'b1;
    end
  end

  // Arbitration and credit state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio_q    <= 1'b0;
      free_q[0] <= CW'(FIFO_D);
      free_q[1] <= CW'(FIFO_D);
    end else begin
      prio_q    <= prio_d;
      free_q[0] <= free_d[0];
      free_q[1] <= free_d[1];
    end
  end

  // Issue register; operands hold when nothing is granted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fdiv_en_q <= 1'b0;
      fdiv_x1_q <= '0;
      fdiv_x2_q <= '0;
      owner_q   <= 1'b0;
    end else begin
      fdiv_en_q <= |grant;
      if (|grant) begin
        owner_q   <= grant[1];
        fdiv_x1_q <= grant[1] ? req1_x1 : req0_x1;
        fdiv_x2_q <= grant[1] ? req1_x2 : req0_x2;
      end
    end
  end

  assign fdiv_en = fdiv_en_q;
  assign fdiv_x1 = fdiv_x1_q;
  assign fdiv_x2 = fdiv_x2_q;

  // Ownership tags travel alongside the pipeline so the tail lines up with fdiv_y.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= '{valid: fdiv_en_q, id: owner_q};
      for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign tail     = tag_q[LAT-1];
  assign wr_en[0] = tail.valid && (tail.id == 1'b0);
  assign wr_en[1] = tail.valid && (tail.id == 1'b1);

  fdiv_arb_fifo #(
    .DEPTH (FIFO_D),
    .WIDTH (32)
  ) u_fifo0 (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_en[0]),
    .wr_data (fdiv_y),
    .rd_en   (res0_ready),
    .rd_data (res0_y),
    .count   (count0),
    .full    (full0),
    .empty   (empty0)
  );

  fdiv_arb_fifo #(
    .DEPTH (FIFO_D),
    .WIDTH (32)
  ) u_fifo1 (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_en[1]),
    .wr_data (fdiv_y),
    .rd_en   (res1_ready),
    .rd_data (res1_y),
    .count   (count1),
    .full    (full1),
    .empty   (empty1)
  );

  assign res0_valid = !empty0;
  assign res1_valid = !empty1;

  // Buffered results plus spare credits can never exceed the FIFO depth.
  credit0_a: assert property (@(posedge clk) disable iff (!rstn)
    ({1'b0, free_q[0]} + {1'b0, count0}) <= (CW + 1)'(FIFO_D) && !(wr_en[0] && full0));
  credit1_a: assert property (@(posedge clk) disable iff (!rstn)
    ({1'b0, free_q[1]} + {1'b0, count1}) <= (CW + 1)'(FIFO_D) && !(wr_en[1] && full1));

endmodule

// File: tb/tb_fdiv_arb.sv
// Directed bench for fdiv_arb with LAT=5, FIFO_D=4 and a delay-line fdiv model.
module tb_fdiv_arb;

  localparam int unsigned LAT    = 5;
  localparam int unsigned FIFO_D = 4;
  localparam logic [31:0] TWO    = 32'h40000000;
  localparam logic [31:0] THREE  = 32'h40400000;
  localparam logic [31:0] ONE_P5 = 32'h3FC00000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_x1, req0_x2, req1_x1, req1_x2;
  logic        fdiv_en;
  logic [31:0] fdiv_x1, fdiv_x2, fdiv_y;
  logic        res0_valid, res0_ready, res1_valid, res1_ready;
  logic [31:0] res0_y, res1_y;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] tab0 [4] = '{32'h3F800000, 32'h40400000, 32'h40A00000, 32'h40E00000};
  logic [31:0] tab1 [4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
  logic [31:0] quo0 [4] = '{32'h3F000000, 32'h3FC00000, 32'h40200000, 32'h40600000};
  logic [31:0] quo1 [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};

  fdiv_arb #(
    .LAT    (LAT),
    .FIFO_D (FIFO_D)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_x1    (req0_x1),
    .req0_x2    (req0_x2),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_x1    (req1_x1),
    .req1_x2    (req1_x2),
    .fdiv_en    (fdiv_en),
    .fdiv_x1    (fdiv_x1),
    .fdiv_x2    (fdiv_x2),
    .fdiv_y     (fdiv_y),
    .res0_valid (res0_valid),
    .res0_ready (res0_ready),
    .res0_y     (res0_y),
    .res1_valid (res1_valid),
    .res1_ready (res1_ready),
    .res1_y     (res1_y)
  );

  always #5 clk = ~clk;

  // Single-precision <-> real for normal, exactly representable values.
  function automatic real sp2r(input logic [31:0] b);
    logic [10:0] e;
    e = {3'b000, b[30:23]} + 11'd896;
    return $bitstoreal({b[31], e, b[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // External fdiv: LAT-stage delay line of a reference divide.
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= fdiv_en ? r2sp(sp2r(fdiv_x1) / sp2r(fdiv_x2)) : 32'hDEADBEEF;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign fdiv_y = pipe[LAT-1];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rstn       = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_x1    = '0;
    req0_x2    = '0;
    req1_x1    = '0;
    req1_x2    = '0;
    res0_ready = 1'b0;
    res1_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    rstn       = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_x1    = THREE;
    req0_x2    = TWO;
    req1_x1    = THREE;
    req1_x2    = TWO;
    res0_ready = 1'b1;
    res1_ready = 1'b1;
    tick();
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b want 00", {req1_ready, req0_ready});
    end
    n_checks++;
    if ({fdiv_en, res0_valid, res1_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_valids: got %b want 000", {fdiv_en, res0_valid, res1_valid});
    end
    n_checks++;
    if ({fdiv_x1, fdiv_x2} !== 64'h0) begin
      n_fail++; $display("FAIL reset_operands: got %h want 0", {fdiv_x1, fdiv_x2});
    end
    n_checks++;
    if (dut.free_q[0] !== 3'd4 || dut.free_q[1] !== 3'd4) begin
      n_fail++; $display("FAIL reset_free: got %0d/%0d want 4/4", dut.free_q[0], dut.free_q[1]);
    end
  endtask

  task automatic test_single;
    apply_reset();
    res0_ready = 1'b1;
    req0_valid = 1'b1;
    req0_x1    = THREE;
    req0_x2    = TWO;
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_fail++; $display("FAIL single_grant: got %b want 01", {req1_ready, req0_ready});
    end
    tick();
    req0_valid = 1'b0;
    #1;
    n_checks++;
    if (fdiv_en !== 1'b1 || fdiv_x1 !== THREE || fdiv_x2 !== TWO) begin
      n_fail++; $display("FAIL single_issue: got en=%b %h/%h want 1 %h/%h",
                         fdiv_en, fdiv_x1, fdiv_x2, THREE, TWO);
    end
    for (int c = 2; c <= 6; c++) begin
      tick();
      n_checks++;
      if (res0_valid !== 1'b0) begin
        n_fail++; $display("FAIL single_early_c%0d: res0_valid=%b want 0", c, res0_valid);
      end
      if (c == 2) begin
        n_checks++;
        if (fdiv_en !== 1'b0 || fdiv_x1 !== THREE) begin
          n_fail++; $display("FAIL single_hold: got en=%b x1=%h want 0 %h", fdiv_en, fdiv_x1, THREE);
        end
      end
    end
    tick();
    n_checks++;
    if (res0_valid !== 1'b1 || res0_y !== ONE_P5 || res1_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_result: got v=%b y=%h v1=%b want 1 %h 0",
                         res0_valid, res0_y, res1_valid, ONE_P5);
    end
    tick();
    n_checks++;
    if (res0_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_popped: res0_valid=%b want 0", res0_valid);
    end
  endtask

  task automatic test_contention;
    int g0, g1, k0, k1;
    logic [1:0] want;
    apply_reset();
    res0_ready = 1'b1;
    res1_ready = 1'b1;
    g0 = 0; g1 = 0; k0 = 0; k1 = 0;
    for (int c = 0; c < 22; c++) begin
      req0_valid = (g0 < 4);
      req1_valid = (g1 < 4);
      req0_x1    = tab0[g0[1:0]];
      req0_x2    = TWO;
      req1_x1    = tab1[g1[1:0]];
      req1_x2    = TWO;
      #1;
      if (c < 8) begin
        want = (c % 2 == 0) ? 2'b01 : 2'b10;
        n_checks++;
        if ({req1_ready, req0_ready} !== want) begin
          n_fail++; $display("FAIL contention_grant_c%0d: got %b want %b",
                             c, {req1_ready, req0_ready}, want);
        end
      end
      if (c >= 1 && c <= 8) begin
        n_checks++;
        if (fdiv_en !== 1'b1) begin
          n_fail++; $display("FAIL contention_issue_c%0d: fdiv_en=%b want 1", c, fdiv_en);
        end
      end
      if (res0_valid) begin
        n_checks++;
        if (k0 >= 4 || res0_y !== quo0[k0[1:0]]) begin
          n_fail++; $display("FAIL contention_res0_%0d: got %h want %h", k0, res0_y, quo0[k0[1:0]]);
        end
        k0++;
      end
      if (res1_valid) begin
        n_checks++;
        if (k1 >= 4 || res1_y !== quo1[k1[1:0]]) begin
          n_fail++; $display("FAIL contention_res1_%0d: got %h want %h", k1, res1_y, quo1[k1[1:0]]);
        end
        k1++;
      end
      if (req0_ready) g0++;
      if (req1_ready) g1++;
      tick();
    end
    n_checks++;
    if (k0 != 4 || k1 != 4) begin
      n_fail++; $display("FAIL contention_count: got %0d/%0d results want 4/4", k0, k1);
    end
  endtask

  // Credit exhaustion followed by requester 1 running while requester 0 is stalled.
  task automatic test_credit_and_fairness;
    apply_reset();
    req0_valid = 1'b1;
    req0_x1    = THREE;
    req0_x2    = TWO;
    for (int c = 0; c < 12; c++) begin
      #1;
      n_checks++;
      if (req0_ready !== (c < 4)) begin
        n_fail++; $display("FAIL credit_c%0d: req0_ready=%b want %b", c, req0_ready, c < 4);
      end
      tick();
    end
    res0_ready = 1'b1;
    #1;
    n_checks++;
    if (res0_valid !== 1'b1 || res0_y !== ONE_P5 || req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL credit_pop: got v=%b y=%h rdy=%b want 1 %h 0",
                         res0_valid, res0_y, req0_ready, ONE_P5);
    end
    tick();
    res0_ready = 1'b0;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL credit_regrant: req0_ready=%b want 1", req0_ready);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (req0_ready !== 1'b0) begin
        n_fail++; $display("FAIL credit_restall_%0d: req0_ready=%b want 0", c, req0_ready);
      end
    end
    tick();
    req1_valid = 1'b1;
    req1_x1    = THREE;
    req1_x2    = TWO;
    res1_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if ({req1_ready, req0_ready} !== ((c < 4) ? 2'b10 : 2'b00)) begin
        n_fail++; $display("FAIL fair_c%0d: got %b want %b", c, {req1_ready, req0_ready},
                           (c < 4) ? 2'b10 : 2'b00);
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_grant_pop;
    apply_reset();
    req0_valid = 1'b1;
    req0_x1    = THREE;
    req0_x2    = TWO;
    repeat (7) tick();
    #1;
    n_checks++;
    if (res0_valid !== 1'b1 || dut.free_q[0] !== 3'd0 || req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL gp_t0: got v=%b free=%0d rdy=%b want 1 0 0",
                         res0_valid, dut.free_q[0], req0_ready);
    end
    res0_ready = 1'b1;
    tick();
    n_checks++;
    if (dut.free_q[0] !== 3'd1 || req0_ready !== 1'b1 || res0_valid !== 1'b1) begin
      n_fail++; $display("FAIL gp_t1: got free=%0d rdy=%b v=%b want 1 1 1",
                         dut.free_q[0], req0_ready, res0_valid);
    end
    tick();
    req0_valid = 1'b0;
    res0_ready = 1'b0;
    #1;
    n_checks++;
    if (dut.free_q[0] !== 3'd1) begin
      n_fail++; $display("FAIL gp_t2: free0=%0d want 1", dut.free_q[0]);
    end
    res0_ready = 1'b1;
    repeat (12) tick();
    n_checks++;
    if (dut.free_q[0] !== 3'd4 || res0_valid !== 1'b0) begin
      n_fail++; $display("FAIL gp_drain: got free=%0d v=%b want 4 0", dut.free_q[0], res0_valid);
    end
  endtask

  task automatic test_reset_mid;
    apply_reset();
    req0_valid = 1'b1;
    req0_x1    = THREE;
    req0_x2    = TWO;
    tick();
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_x1    = 32'h40800000;
    req1_x2    = TWO;
    for (int c = 2; c < 5; c++) begin
      #1;
      n_checks++;
      if ({req1_ready, req0_ready} !== 2'b10) begin
        n_fail++; $display("FAIL mid_grant_c%0d: got %b want 10", c, {req1_ready, req0_ready});
      end
      tick();
    end
    req1_valid = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (res0_valid !== 1'b1 || res1_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_pre: got v0=%b v1=%b want 1 0", res0_valid, res1_valid);
    end
    req0_valid = 1'b1;
    rstn       = 1'b0;
    #1;
    n_checks++;
    if ({res0_valid, res1_valid, fdiv_en, req0_ready} !== 4'b0000 || fdiv_x1 !== 32'h0) begin
      n_fail++; $display("FAIL mid_async: got %b x1=%h want 0000 0",
                         {res0_valid, res1_valid, fdiv_en, req0_ready}, fdiv_x1);
    end
    tick();
    tick();
    req0_valid = 1'b0;
    res0_ready = 1'b1;
    res1_ready = 1'b1;
    rstn       = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      n_checks++;
      if (res0_valid !== 1'b0 || res1_valid !== 1'b0) begin
        n_fail++; $display("FAIL mid_stale_c%0d: got v0=%b v1=%b want 0 0", c, res0_valid, res1_valid);
      end
      tick();
    end
    n_checks++;
    if (dut.free_q[0] !== 3'd4 || dut.free_q[1] !== 3'd4) begin
      n_fail++; $display("FAIL mid_free: got %0d/%0d want 4/4", dut.free_q[0], dut.free_q[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_credit_and_fairness();
    test_grant_pop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
